// File: rtl/mkio_rx_decoder_if.sv
// Receive-side bundle between the 1553 transceiver RX pair and the terminal logic.
// The master drives the line and enable; the slave (decoder) returns decoded words.
interface mkio_rx_decoder_if;
   logic        en;
   logic        din_p;
   logic        din_n;
   logic [15:0] rx_data;
   logic        rx_done;
   logic        rx_cd;
   logic        p_error;
   logic        m_error;
   logic        rx_busy;

   modport master (
      output en, din_p, din_n,
      input  rx_data, rx_done, rx_cd, p_error, m_error, rx_busy
   );

   modport slave (
      input  en, din_p, din_n,
      output rx_data, rx_done, rx_cd, p_error, m_error, rx_busy
   );
endinterface

// File: rtl/mkio_rx_decoder.sv
// MIL-STD-1553 Manchester-II word receiver: sync validation, 16 data bits and odd parity.
// The line is sampled SPB times per bit; all word timing counts from the sync mid-edge (t=0).
module mkio_rx_decoder #(
   parameter int SPB = 16
) (
   input logic              clk,
   input logic              reset,
   mkio_rx_decoder_if.slave bus
);
   typedef enum logic [1:0] {L_IDLE, L_POS, L_NEG} lvl_t;
   typedef enum logic [1:0] {S_IDLE, S_SYNC_CHK, S_BITS, S_ABORT} state_t;

   // Timeline is 11 bits so 18.25*SPB still fits at SPB=64.
   localparam int              TW        = 11;
   localparam logic [7:0]      RUN_MAX   = 8'(2*SPB);
   localparam logic [7:0]      RUN_LO    = 8'(SPB + SPB/4);
   localparam logic [7:0]      RUN_HI    = 8'(SPB + 3*SPB/4);
   localparam logic [TW-1:0]   T_ONE     = TW'(1);
   localparam logic [TW-1:0]   T_SYNC_A  = TW'(SPB/2);
   localparam logic [TW-1:0]   T_SYNC_B  = TW'(SPB);
   localparam logic [TW-1:0]   T_BIT0_H1 = TW'(3*SPB/2 + SPB/4);
   localparam logic [TW-1:0]   T_HALF    = TW'(SPB/2);
   localparam logic [TW-1:0]   T_BIT     = TW'(SPB);

   logic          r_p_s1, r_p_s2, r_n_s1, r_n_s2;
   state_t        r_state;
   lvl_t          r_lvl;
   lvl_t          r_h1;
   logic [7:0]    r_run;
   logic [TW-1:0] r_t;
   logic [TW-1:0] r_t_h1;
   logic [4:0]    r_k;
   logic          r_cd_lat;
   logic [15:0]   r_shift;
   logic          r_par;
   logic [15:0]   r_rx_data;
   logic          r_rx_done;
   logic          r_rx_cd;
   logic          r_p_error;
   logic          r_m_error;
   logic          r_rx_busy;

   lvl_t          w_lvl;
   lvl_t          w_sec_lvl;
   logic          w_flip;
   logic          w_run_ok;
   logic          w_at_h1;
   logic          w_at_h2;
   logic          w_bit_ok;
   logic          w_bit_val;
   logic          w_last_bit;
   logic          w_shift_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {r_p_s1, r_p_s2, r_n_s1, r_n_s2} <= 4'b0000;
      end else begin
         r_p_s1 <= bus.din_p;
         r_p_s2 <= r_p_s1;
         r_n_s1 <= bus.din_n;
         r_n_s2 <= r_n_s1;
      end
   end

   always_comb begin
      w_lvl = L_IDLE;
      if (r_p_s2 && !r_n_s2)
         w_lvl = L_POS;
      else if (r_n_s2 && !r_p_s2)
         w_lvl = L_NEG;
   end

   assign w_flip     = ((r_lvl == L_POS) && (w_lvl == L_NEG)) ||
                       ((r_lvl == L_NEG) && (w_lvl == L_POS));
   assign w_run_ok   = (r_run >= RUN_LO) && (r_run <= RUN_HI);
   assign w_sec_lvl  = r_cd_lat ? L_NEG : L_POS;
   assign w_at_h1    = (r_t == r_t_h1);
   assign w_at_h2    = (r_t == (r_t_h1 + T_HALF));
   assign w_bit_ok   = (w_lvl != L_IDLE) && (w_lvl != r_h1);
   assign w_bit_val  = (r_h1 == L_POS);
   assign w_last_bit = (r_k == 5'd16);
   assign w_shift_en = bus.en && (r_state == S_BITS) && w_at_h2 && w_bit_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_lvl     <= L_IDLE;
         r_h1      <= L_IDLE;
         r_run     <= '0;
         r_t       <= '0;
         r_t_h1    <= '0;
         r_k       <= '0;
         r_cd_lat  <= 1'b0;
         r_rx_data <= '0;
         r_rx_done <= 1'b0;
         r_rx_cd   <= 1'b0;
         r_p_error <= 1'b0;
         r_m_error <= 1'b0;
         r_rx_busy <= 1'b0;
      end else begin
         r_rx_done <= 1'b0;
         r_m_error <= 1'b0;
         r_lvl     <= w_lvl;
         if (w_lvl == L_IDLE)
            r_run <= '0;
         else if (w_lvl != r_lvl)
            r_run <= 8'd1;
         else if (r_run < RUN_MAX)
            r_run <= r_run + 8'd1;

         if (!bus.en) begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_rx_busy <= 1'b0;
            r_rx_cd   <= 1'b0;
            r_p_error <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_flip && w_run_ok) begin
                     r_cd_lat  <= (r_lvl == L_POS);
                     r_t       <= T_ONE;
                     r_t_h1    <= T_BIT0_H1;
                     r_k       <= '0;
                     r_rx_busy <= 1'b1;
                     r_state   <= S_SYNC_CHK;
                  end
               end
               S_SYNC_CHK: begin
                  r_t <= r_t + T_ONE;
                  if (((r_t == T_SYNC_A) || (r_t == T_SYNC_B)) && (w_lvl != w_sec_lvl)) begin
                     r_state   <= S_ABORT;
                     r_m_error <= 1'b1;
                     r_rx_busy <= 1'b0;
                  end else if (r_t == T_SYNC_B) begin
                     r_state <= S_BITS;
                  end
               end
               S_BITS: begin
                  r_t <= r_t + T_ONE;
                  if (w_at_h1) begin
                     r_h1 <= w_lvl;
                     if (w_lvl == L_IDLE) begin
                        r_state   <= S_ABORT;
                        r_m_error <= 1'b1;
                        r_rx_busy <= 1'b0;
                     end
                  end else if (w_at_h2) begin
                     if (!w_bit_ok) begin
                        r_state   <= S_ABORT;
                        r_m_error <= 1'b1;
                        r_rx_busy <= 1'b0;
                     end else if (w_last_bit) begin
                        // Parity half-bit is folded in here, so the total XOR is complete this cycle.
                        r_rx_done <= 1'b1;
                        r_rx_data <= r_shift;
                        r_rx_cd   <= r_cd_lat;
                        r_p_error <= ~(r_par ^ w_bit_val);
                        r_rx_busy <= 1'b0;
                        r_run     <= '0;
                        r_state   <= S_IDLE;
                     end else begin
                        r_k    <= r_k + 5'd1;
                        r_t_h1 <= r_t_h1 + T_BIT;
                     end
                  end
               end
               S_ABORT: begin
                  r_run   <= '0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Shift register and parity are fully rewritten each word, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_shift_en) begin
         if (!w_last_bit)
            r_shift <= {r_shift[14:0], w_bit_val};
         r_par <= (r_k == 5'd0) ? w_bit_val : (r_par ^ w_bit_val);
      end
   end

   assign bus.rx_data = r_rx_data;
   assign bus.rx_done = r_rx_done;
   assign bus.rx_cd   = r_rx_cd;
   assign bus.p_error = r_p_error;
   assign bus.m_error = r_m_error;
   assign bus.rx_busy = r_rx_busy;
endmodule

// File: tb/tb_mkio_rx_decoder.sv
// Bench for mkio_rx_decoder: builds Manchester waveforms from word descriptions, predicts
// each rx_done / m_error event from the protocol rules, and a monitor matches the pulses.
module tb_mkio_rx_decoder;
   localparam int S        = 16;
   localparam int LAT_DONE = 2 + (73*S)/4 + 1;

   typedef struct {
      bit          is_done;
      logic [15:0] data;
      bit          cd;
      bit          perr;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   logic [15:0] hd_data = '0;
   bit          hd_cd   = 1'b0;
   bit          hd_perr = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mkio_rx_decoder_if bus();
   mkio_rx_decoder #(.SPB(S)) dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_line(input int l);
      bus.din_p = (l == 1);
      bus.din_n = (l == 2);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         set_line(0);
      end
   endtask

   task automatic check_zero_outputs();
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_rx_done", 32'(bus.rx_done), 32'd0);
      check("rst_rx_cd",   32'(bus.rx_cd),   32'd0);
      check("rst_p_error", 32'(bus.p_error), 32'd0);
      check("rst_m_error", 32'(bus.m_error), 32'd0);
      check("rst_rx_busy", 32'(bus.rx_busy), 32'd0);
   endtask

   // One word on the line. Level codes: 0 idle, 1 POS, 2 NEG. flen = first sync half in samples,
   // bad_k = bit sent as POS/POS, rst_at / en_at = sample after the sync edge to reset / disable.
   task automatic send_word(input bit cd, input logic [15:0] data, input bit pbit, input int flen,
                            input int bad_k, input int rst_at, input int en_at);
      int   lv[$];
      int   a, b, bitv;
      bit   accept;
      exp_t e;
      a = cd ? 1 : 2;
      b = cd ? 2 : 1;
      accept = (flen >= S + S/4) && (flen <= S + 3*S/4);
      repeat (flen) lv.push_back(a);
      repeat (3*S/2) lv.push_back(b);
      if (accept) begin
         for (int k = 0; k < 17; k++) begin
            bitv = (k < 16) ? int'(data[15-k]) : int'(pbit);
            if (k == bad_k) begin
               repeat (S) lv.push_back(1);
               break;
            end
            repeat (S/2) lv.push_back(bitv != 0 ? 1 : 2);
            repeat (S/2) lv.push_back(bitv != 0 ? 2 : 1);
         end
      end
      for (int i = 0; i < lv.size(); i++) begin
         @(negedge clk);
         if (rst_at >= 0 && i == flen + rst_at) begin
            check("busy_before_reset", 32'(bus.rx_busy), 32'd1);
            set_line(0);
            reset = 1'b1;
            #1;
            check_zero_outputs();
            repeat (3) @(negedge clk);
            reset   = 1'b0;
            hd_data = '0;
            hd_cd   = 1'b0;
            hd_perr = 1'b0;
            return;
         end
         if (en_at >= 0 && i == flen + en_at) begin
            check("busy_before_en_low", 32'(bus.rx_busy), 32'd1);
            set_line(0);
            bus.en = 1'b0;
            repeat (2) @(negedge clk);
            check("en_low_busy",    32'(bus.rx_busy), 32'd0);
            check("en_low_cd",      32'(bus.rx_cd),   32'd0);
            check("en_low_perr",    32'(bus.p_error), 32'd0);
            check("en_low_data",    32'(bus.rx_data), 32'(hd_data));
            bus.en  = 1'b1;
            hd_cd   = 1'b0;
            hd_perr = 1'b0;
            return;
         end
         set_line(lv[i]);
         if (i == flen && accept && rst_at < 0 && en_at < 0) begin
            if (bad_k >= 0) begin
               e.is_done = 1'b0;
               e.cyc     = cyc + 2 + 3*S/2 + bad_k*S + 3*S/4 + 1;
               e.data    = hd_data;
               e.cd      = hd_cd;
               e.perr    = hd_perr;
            end else begin
               e.is_done = 1'b1;
               e.cyc     = cyc + LAT_DONE;
               e.data    = data;
               e.cd      = cd;
               e.perr    = ~(^data ^ pbit);
               hd_data   = e.data;
               hd_cd     = e.cd;
               hd_perr   = e.perr;
            end
            exp_q.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && (bus.rx_done || bus.m_error)) begin
         check("pulse_exclusive", 32'(bus.rx_done & bus.m_error), 32'd0);
         check("busy_at_word_end", 32'(bus.rx_busy), 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: got done=%0b merr=%0b, want no pulse (cycle %0d)",
                     bus.rx_done, bus.m_error, cyc);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind_done", 32'(bus.rx_done), 32'(e.is_done));
            check("pulse_cycle",     32'(cyc),         32'(e.cyc));
            check("rx_data",         32'(bus.rx_data), 32'(e.data));
            check("rx_cd",           32'(bus.rx_cd),   32'(e.cd));
            check("p_error",         32'(bus.p_error), 32'(e.perr));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded its time budget (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] rd;
      bit          rcd, rpb;
      int          gap, fl;
      bus.en = 1'b1;
      set_line(0);
      repeat (3) @(negedge clk);
      check_zero_outputs();
      reset = 1'b0;
      idle(10);

      // Command word with correct parity, then a data word with parity error and a recovery word.
      send_word(1'b1, 16'h8421, ~^16'h8421, 24, -1, -1, -1);
      idle(20);
      send_word(1'b0, 16'hFFFF, 1'b0, 24, -1, -1, -1);
      idle(20);
      send_word(1'b1, 16'h1357, ~^16'h1357, 24, -1, -1, -1);
      idle(20);

      // Four words with no gap.
      send_word(1'b1, 16'hA5C3, ~^16'hA5C3, 24, -1, -1, -1);
      send_word(1'b0, 16'h0001, ~^16'h0001, 24, -1, -1, -1);
      send_word(1'b0, 16'hFFFE, ~^16'hFFFE, 24, -1, -1, -1);
      send_word(1'b0, 16'h7FFF, ~^16'h7FFF, 24, -1, -1, -1);
      idle(20);

      // Bit 5 with equal halves.
      send_word(1'b1, 16'h1234, ~^16'h1234, 24, 5, -1, -1);
      idle(40);

      // Sync first-half length boundaries.
      send_word(1'b1, 16'h0000, 1'b0, 16, -1, -1, -1);
      idle(40);
      check("busy_after_short_sync", 32'(bus.rx_busy), 32'd0);
      send_word(1'b0, 16'h0000, 1'b0, 32, -1, -1, -1);
      idle(40);
      check("busy_after_long_sync", 32'(bus.rx_busy), 32'd0);
      send_word(1'b1, 16'h5A0F, ~^16'h5A0F, 20, -1, -1, -1);
      idle(20);
      send_word(1'b0, 16'hC3A5, ~^16'hC3A5, 28, -1, -1, -1);
      idle(20);

      // Reset in the middle of a word, then a clean word.
      send_word(1'b1, 16'hC0DE, ~^16'hC0DE, 24, -1, 150, -1);
      idle(10);
      send_word(1'b0, 16'h0F0F, ~^16'h0F0F, 24, -1, -1, -1);
      idle(20);

      // Enable dropped mid-word after a command word with a parity error.
      send_word(1'b1, 16'h00FF, ^16'h00FF, 24, -1, -1, -1);
      idle(20);
      send_word(1'b0, 16'hBEEF, ~^16'hBEEF, 24, -1, -1, 150);
      idle(10);
      send_word(1'b1, 16'h2468, ~^16'h2468, 24, -1, -1, -1);
      idle(20);

      // Random words: random gap (sometimes none), sync length, sync type and parity.
      for (int w = 0; w < 12; w++) begin
         rd  = 16'($urandom);
         rcd = 1'($urandom_range(0, 1));
         rpb = ($urandom_range(0, 3) == 0) ? ^rd : ~^rd;
         gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
         fl  = (gap == 0) ? 24 : int'($urandom_range(S + S/4, S + 3*S/4));
         if (gap > 0) idle(gap);
         send_word(rcd, rd, rpb, fl, -1, -1, -1);
      end
      idle(5);

      for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_rx_data", 32'(bus.rx_data), 32'(hd_data));
      check("final_p_error", 32'(bus.p_error), 32'(hd_perr));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
